// File: rtl/keypad_pkg.sv
// Shared types, key-code constants and the Pmod KYPD row/column-to-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_BLANK     = 4'hF;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

    typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_t;

    typedef enum logic [1:0] {
        DEB_RELEASED,
        DEB_PRESS_PENDING,
        DEB_PRESSED,
        DEB_RELEASE_PENDING
    } deb_state_t;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input col_state_t col);
        logic [3:0] drive;
        case (col)
            COL0:    drive = 4'b1110;
            COL1:    drive = 4'b1101;
            COL2:    drive = 4'b1011;
            default: drive = 4'b0111;
        endcase
        return drive;
    endfunction

    function automatic col_state_t next_col(input col_state_t col);
        col_state_t nxt;
        case (col)
            COL0:    nxt = COL1;
            COL1:    nxt = COL2;
            COL2:    nxt = COL3;
            default: nxt = COL0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key/display outputs of the scanner.
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;
    logic [3:0] disp_val;
    logic       digit_adv;

    modport master (
        input  row_n,
        output col_n, key_code, key_valid, key_held, multi_key, disp_val, digit_adv
    );

    modport slave (
        output row_n,
        input  col_n, key_code, key_valid, key_held, multi_key, disp_val, digit_adv
    );
endinterface

// File: rtl/keypad_debounce.sv
// Per-scan debounce FSM: accepts a key after DEBOUNCE_SCANS identical scans, releases likewise.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       strobe,
    input  scan_kind_t kind,
    input  logic [3:0] code_in,
    output logic       accept,
    output logic       release_evt,
    output logic       held,
    output logic [3:0] code
);

    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    deb_state_t state;
    logic [3:0] cand;
    logic [CW-1:0] count;
    logic single, same;

    assign single = (kind == SCAN_SINGLE);
    assign same   = single && (code_in == cand);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= DEB_RELEASED;
            cand        <= 4'h0;
            count       <= '0;
            accept      <= 1'b0;
            release_evt <= 1'b0;
            held        <= 1'b0;
            code        <= 4'h0;
        end else begin
            accept      <= 1'b0;
            release_evt <= 1'b0;
            if (strobe) begin
                case (state)
                    DEB_RELEASED: begin
                        if (single) begin
                            cand  <= code_in;
                            count <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state  <= DEB_PRESSED;
                                accept <= 1'b1;
                                held   <= 1'b1;
                                code   <= code_in;
                            end else begin
                                state <= DEB_PRESS_PENDING;
                            end
                        end
                    end
                    DEB_PRESS_PENDING: begin
                        if (same) begin
                            count <= count + CW'(1);
                            if (count == CW'(DEBOUNCE_SCANS - 1)) begin
                                state  <= DEB_PRESSED;
                                accept <= 1'b1;
                                held   <= 1'b1;
                                code   <= cand;
                            end
                        end else if (single) begin
                            cand  <= code_in;
                            count <= CW'(1);
                        end else begin
                            state <= DEB_RELEASED;
                            count <= '0;
                        end
                    end
                    DEB_PRESSED: begin
                        if (!same) begin
                            count <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                state       <= DEB_RELEASED;
                                held        <= 1'b0;
                                release_evt <= 1'b1;
                            end else begin
                                state <= DEB_RELEASE_PENDING;
                            end
                        end
                    end
                    default: begin
                        if (same) begin
                            state <= DEB_PRESSED;
                            count <= '0;
                        end else if (count == CW'(DEBOUNCE_SCANS - 1)) begin
                            state       <= DEB_RELEASED;
                            count       <= '0;
                            held        <= 1'b0;
                            release_evt <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchroniser, column scan, per-scan decode, debounce, display digit.
// Optional KEYPAD_AUTO_ADVANCE_EN: pulse digit_adv one cycle after each accepted digit key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned COL_CYCLES     = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input logic              clock,
    input logic              reset_n,
    keypad_scanner_if.master bus
);

    localparam int unsigned DW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;

    logic [3:0]    row_meta, row_sync;
    col_state_t    col_state;
    logic [DW-1:0] dwell;
    logic          run;
    logic [3:0]    col_n_q;
    logic [15:0]   mask, mask_c;
    logic          multi_q;
    logic [3:0]    digit_q;
    logic          sample_c, last_c;
    logic [1:0]    hits_c;
    logic [3:0]    code_c;
    scan_kind_t    kind_c;
    logic          accept, release_evt, held;
    logic [3:0]    code;

    assign sample_c = run && (dwell == DW'(COL_CYCLES - 1));
    assign last_c   = sample_c && (col_state == COL3);

    // Fold the current column's rows into the mask and classify the scan.
    always_comb begin
        mask_c = mask;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) mask_c[{2'(r), 2'(col_state)}] = 1'b1;
        end
        hits_c = 2'd0;
        code_c = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (mask_c[i]) begin
                code_c = key_map(2'(i >> 2), 2'(i));
                if (hits_c != 2'd2) hits_c = hits_c + 2'd1;
            end
        end
        case (hits_c)
            2'd0:    kind_c = SCAN_NONE;
            2'd1:    kind_c = SCAN_SINGLE;
            default: kind_c = SCAN_MULTI;
        endcase
    end

    // The first cycle after reset only arms the scan so COL0 starts with dwell=0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            col_state <= COL0;
            dwell     <= '0;
            run       <= 1'b0;
            col_n_q   <= 4'b1111;
            mask      <= '0;
            multi_q   <= 1'b0;
            digit_q   <= KEY_BLANK;
        end else begin
            row_meta <= bus.row_n;
            row_sync <= row_meta;
            if (!run) begin
                run     <= 1'b1;
                col_n_q <= col_drive(COL0);
            end else if (sample_c) begin
                dwell     <= '0;
                col_state <= next_col(col_state);
                col_n_q   <= col_drive(next_col(col_state));
            end else begin
                dwell <= dwell + DW'(1);
            end
            if (last_c) begin
                mask    <= '0;
                multi_q <= (kind_c == SCAN_MULTI);
            end else if (sample_c) begin
                mask <= mask_c;
            end
            if (accept && (code <= KEY_MAX_DIGIT)) digit_q <= code;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clock      (clock),
        .reset_n    (reset_n),
        .strobe     (last_c),
        .kind       (kind_c),
        .code_in    (code_c),
        .accept     (accept),
        .release_evt(release_evt),
        .held       (held),
        .code       (code)
    );

    assert property (@(posedge clock) disable iff (!reset_n)
        (release_evt |-> !held) and (accept |-> held));

    assign bus.col_n     = col_n_q;
    assign bus.key_code  = code;
    assign bus.key_valid = accept;
    assign bus.key_held  = held;
    assign bus.multi_key = multi_q;
    assign bus.disp_val  = (accept && (code <= KEY_MAX_DIGIT)) ? code : digit_q;

`ifdef KEYPAD_AUTO_ADVANCE_EN
    logic adv_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) adv_q <= 1'b0;
        else          adv_q <= accept && (code <= KEY_MAX_DIGIT);
    end
    assign bus.digit_adv = adv_q;
`else
    assign bus.digit_adv = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a combinational 4x4 matrix model.
module tb_keypad_scanner;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] keys = 16'h0000;
    logic [3:0]  row_model;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;

    typedef struct {
        logic [3:0] code;
        logic [3:0] disp;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner_if bus ();

    keypad_scanner #(.COL_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_model[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.col_n[c]) row_model[r] = 1'b0;
        end
    end
    assign bus.row_n = row_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_col_n"},     32'(bus.col_n),     32'hF);
        check({tag, "_key_code"},  32'(bus.key_code),  32'h0);
        check({tag, "_key_valid"}, 32'(bus.key_valid), 32'h0);
        check({tag, "_key_held"},  32'(bus.key_held),  32'h0);
        check({tag, "_multi_key"}, 32'(bus.multi_key), 32'h0);
        check({tag, "_disp_val"},  32'(bus.disp_val),  32'hF);
        check({tag, "_digit_adv"}, 32'(bus.digit_adv), 32'h0);
    endtask

    // Monitor: every key_valid pops one expected event; digit_adv checked on the following cycle.
    initial begin : monitor
        logic adv_pending;
        logic adv_exp;
        exp_t e;
        adv_pending = 1'b0;
        adv_exp     = 1'b0;
        forever begin
            @(negedge clock);
            if (adv_pending) begin
                check("digit_adv", 32'(bus.digit_adv), 32'(adv_exp));
                adv_pending = 1'b0;
            end
            if (bus.key_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_key_valid: got code %0h, expected no event", bus.key_code);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_key_code", 32'(bus.key_code), 32'(e.code));
                    check("ev_disp_val", 32'(bus.disp_val), 32'(e.disp));
                    check("ev_key_held", 32'(bus.key_held), 32'h1);
                end
`ifdef KEYPAD_AUTO_ADVANCE_EN
                adv_exp = (bus.key_code <= 4'h9);
`else
                adv_exp = 1'b0;
`endif
                adv_pending = 1'b1;
            end
        end
    end

    initial begin : stimulus
        int p0;
        logic [3:0] prev_col;
        logic aligned;

        // 1: reset values, then column rotation with 4-cycle dwell
        cycles(10);
        check_reset_values("rst");
        reset_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            logic [3:0] exp_col;
            @(negedge clock);
            case (((j - 1) / 4) % 4)
                0:       exp_col = 4'b1110;
                1:       exp_col = 4'b1101;
                2:       exp_col = 4'b1011;
                default: exp_col = 4'b0111;
            endcase
            check("col_scan", 32'(bus.col_n), 32'(exp_col));
        end

        // 4: keys 1 and 2 together -> multi_key, no event, display still blank
        p0 = pulses;
        keys = 16'h0003;
        cycles(48);
        check("multi_key_on", 32'(bus.multi_key), 32'h1);
        cycles(16);
        check("multi_key_still", 32'(bus.multi_key), 32'h1);
        check("multi_disp_blank", 32'(bus.disp_val), 32'hF);
        keys = 16'h0000;
        cycles(48);
        check("multi_key_off", 32'(bus.multi_key), 32'h0);
        check("multi_no_pulse", 32'(pulses - p0), 32'h0);

        // 2: key '5' held 200 cycles
        p0 = pulses;
        exp_q.push_back('{code: 4'h5, disp: 4'h5});
        keys = 16'h0020;
        cycles(200);
        check("k5_pulses", 32'(pulses - p0), 32'h1);
        check("k5_code", 32'(bus.key_code), 32'h5);
        check("k5_disp", 32'(bus.disp_val), 32'h5);
        check("k5_held", 32'(bus.key_held), 32'h1);
        keys = 16'h0000;
        cycles(52);
        check("k5_released", 32'(bus.key_held), 32'h0);
        cycles(16);

        // 3: key '3' bouncing then stable
        p0 = pulses;
        exp_q.push_back('{code: 4'h3, disp: 4'h3});
        for (int i = 0; i < 13; i++) begin
            keys[2] = ~keys[2];
            cycles(3);
        end
        keys = 16'h0004;
        cycles(200);
        check("k3_pulses", 32'(pulses - p0), 32'h1);
        check("k3_code", 32'(bus.key_code), 32'h3);
        keys = 16'h0000;
        cycles(68);

        // 5: '7' then 'A'
        p0 = pulses;
        exp_q.push_back('{code: 4'h7, disp: 4'h7});
        keys = 16'h0100;
        cycles(120);
        keys = 16'h0000;
        cycles(68);
        exp_q.push_back('{code: 4'hA, disp: 4'h7});
        keys = 16'h0008;
        cycles(120);
        keys = 16'h0000;
        cycles(68);
        check("k7a_pulses", 32'(pulses - p0), 32'h2);
        check("k7a_code", 32'(bus.key_code), 32'hA);
        check("k7a_disp", 32'(bus.disp_val), 32'h7);

        // 6: reset while '9' is pending, then recognised afresh
        aligned  = 1'b0;
        prev_col = bus.col_n;
        for (int i = 0; i < 64 && !aligned; i++) begin
            @(negedge clock);
            if (prev_col == 4'b0111 && bus.col_n == 4'b1110) aligned = 1'b1;
            prev_col = bus.col_n;
        end
        check("scan_align", 32'(aligned), 32'h1);
        p0 = pulses;
        keys = 16'h0400;
        cycles(22);
        reset_n = 1'b0;
        @(negedge clock);
        check_reset_values("midrst");
        cycles(5);
        check("midrst_no_pulse", 32'(pulses - p0), 32'h0);
        exp_q.push_back('{code: 4'h9, disp: 4'h9});
        reset_n = 1'b1;
        cycles(200);
        check("k9_pulses", 32'(pulses - p0), 32'h1);
        check("k9_held", 32'(bus.key_held), 32'h1);
        keys = 16'h0000;
        cycles(68);
        check("k9_released", 32'(bus.key_held), 32'h0);
        check("events_consumed", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
